// File: rtl/pool_pkg.sv
// ----------------------------------------------------------------------------
// pool_pkg : shared pixel/window types for the 2x2 pooling datapath
// Rev 1.0  : initial release
// ----------------------------------------------------------------------------
`default_nettype none

package pool_pkg;

  localparam int POOL_DATA_W = 2;
  localparam int POOL_IMG_W  = 8;
  localparam int POOL_IMG_H  = 8;

  typedef logic signed [POOL_DATA_W-1:0] pixel_t;

  typedef struct packed {
    pixel_t a;
    pixel_t b;
    pixel_t c;
    pixel_t d;
  } window_t;

endpackage

`default_nettype wire

// File: rtl/pool_line_buf.sv
// ----------------------------------------------------------------------------
// pool_line_buf : one-row pixel store, single write port, col-1/col read ports
// Rev 1.0       : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module pool_line_buf #(
  parameter int IMG_W  = 8,
  parameter int DATA_W = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_we,
  input  logic [$clog2(IMG_W)-1:0] i_col,
  input  logic signed [DATA_W-1:0] i_wdata,
  output logic signed [DATA_W-1:0] o_left,
  output logic signed [DATA_W-1:0] o_right
);

  localparam int COL_W = $clog2(IMG_W);

  logic signed [DATA_W-1:0] r_mem [IMG_W];
  logic [COL_W-1:0]         w_left_col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IMG_W; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_col] <= i_wdata;
    end
  end

  // Reads are only consumed on odd columns, so col-1 never underflows.
  assign w_left_col = i_col - COL_W'(1);
  assign o_left     = r_mem[w_left_col];
  assign o_right    = r_mem[i_col];

endmodule

`default_nettype wire

// File: rtl/pool_window_gen.sv
// ----------------------------------------------------------------------------
// pool_window_gen : raster stream -> non-overlapping 2x2 windows (stride 2)
// Rev 1.0         : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module pool_window_gen
  import pool_pkg::*;
#(
  parameter int DATA_W = POOL_DATA_W,
  parameter int IMG_W  = POOL_IMG_W,
  parameter int IMG_H  = POOL_IMG_H
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     win_valid,
  input  logic                     win_ready,
  output logic signed [DATA_W-1:0] win_a,
  output logic signed [DATA_W-1:0] win_b,
  output logic signed [DATA_W-1:0] win_c,
  output logic signed [DATA_W-1:0] win_d,
  output logic                     frame_done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  logic [COL_W-1:0]         r_col;
  logic [ROW_W-1:0]         r_row;
  logic signed [DATA_W-1:0] r_held;
  logic                     r_win_valid;
  logic                     r_win_last;
  logic signed [DATA_W-1:0] r_win_a;
  logic signed [DATA_W-1:0] r_win_b;
  logic signed [DATA_W-1:0] r_win_c;
  logic signed [DATA_W-1:0] r_win_d;

  logic                     w_in_ready;
  logic                     w_beat;
  logic                     w_col_last;
  logic                     w_row_last;
  logic                     w_buf_we;
  logic                     w_hold_we;
  logic                     w_win_load;
  logic                     w_win_take;
  logic signed [DATA_W-1:0] w_buf_left;
  logic signed [DATA_W-1:0] w_buf_right;

  // A window leaving this cycle frees the register for a same-cycle refill.
  assign w_in_ready = ~r_win_valid | win_ready;
  assign w_beat     = in_valid & w_in_ready;
  assign w_col_last = (r_col == COL_W'(IMG_W - 1));
  assign w_row_last = (r_row == ROW_W'(IMG_H - 1));
  assign w_buf_we   = w_beat & ~r_row[0];
  assign w_hold_we  = w_beat &  r_row[0] & ~r_col[0];
  assign w_win_load = w_beat &  r_row[0] &  r_col[0];
  assign w_win_take = r_win_valid & win_ready;

  pool_line_buf #(
    .IMG_W  (IMG_W),
    .DATA_W (DATA_W)
  ) u_line_buf (
    .clk     (clk),
    .rst_n   (rst),
    .i_we    (w_buf_we),
    .i_col   (r_col),
    .i_wdata (in_data),
    .o_left  (w_buf_left),
    .o_right (w_buf_right)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_beat) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_held <= '0;
    end else if (w_hold_we) begin
      r_held <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_win_valid <= 1'b0;
      r_win_last  <= 1'b0;
      r_win_a     <= '0;
      r_win_b     <= '0;
      r_win_c     <= '0;
      r_win_d     <= '0;
    end else if (w_win_load) begin
      r_win_valid <= 1'b1;
      r_win_last  <= w_col_last & w_row_last;
      r_win_a     <= w_buf_left;
      r_win_b     <= w_buf_right;
      r_win_c     <= r_held;
      r_win_d     <= in_data;
    end else if (w_win_take) begin
      r_win_valid <= 1'b0;
    end
  end

  assign in_ready   = w_in_ready;
  assign win_valid  = r_win_valid;
  assign win_a      = r_win_a;
  assign win_b      = r_win_b;
  assign win_c      = r_win_c;
  assign win_d      = r_win_d;
  assign frame_done = w_win_take & r_win_last;

endmodule

`default_nettype wire

// File: tb/tb_pool_window_gen.sv
// ----------------------------------------------------------------------------
// tb_pool_window_gen : randomized scoreboard bench for pool_window_gen (4x4)
// Rev 1.0            : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pool_window_gen;

  localparam int DATA_W = 2;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 4;

  typedef struct {
    int a;
    int b;
    int c;
    int d;
    bit last;
  } exp_win_t;

  logic                     clk;
  logic                     rst_n;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     win_valid;
  logic                     win_ready;
  logic signed [DATA_W-1:0] win_a;
  logic signed [DATA_W-1:0] win_b;
  logic signed [DATA_W-1:0] win_c;
  logic signed [DATA_W-1:0] win_d;
  logic                     frame_done;

  int       n_checks;
  int       n_fail;
  int       n_done;
  int       n_hs;
  int       ready_mode;
  int       frame [IMG_H][IMG_W];
  exp_win_t exp_q [$];

  pool_window_gen #(
    .DATA_W (DATA_W),
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H)
  ) dut (
    .clk        (clk),
    .rst        (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_a      (win_a),
    .win_b      (win_b),
    .win_c      (win_c),
    .win_d      (win_d),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: windows are cut straight from the 2-D frame image.
  task automatic model_frame();
    exp_win_t w;
    for (int r = 0; r < IMG_H / 2; r++) begin
      for (int c = 0; c < IMG_W / 2; c++) begin
        w.a    = frame[2*r][2*c];
        w.b    = frame[2*r][2*c+1];
        w.c    = frame[2*r+1][2*c];
        w.d    = frame[2*r+1][2*c+1];
        w.last = (r == IMG_H / 2 - 1) && (c == IMG_W / 2 - 1);
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic random_frame();
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        frame[r][c] = int'($urandom_range(0, 3)) - 2;
  endtask

  task automatic drive_pixel(input int px, input int gap_pct);
    int guard;
    while (int'($urandom_range(0, 99)) < gap_pct) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = DATA_W'(px);
    guard    = 0;
    @(negedge clk);
    while (!in_ready && guard < 300) begin
      guard++;
      @(negedge clk);
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int gap_pct);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        drive_pixel(frame[r][c], gap_pct);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      guard++;
      @(negedge clk);
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       win_ready = 1'b1;
      1:       win_ready = ($urandom_range(0, 1) == 1);
      default: win_ready = 1'b0;
    endcase
  end

  // Scoreboard: every handshake pops one expected window.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_done) n_done++;
      if (win_valid && win_ready) begin
        n_hs++;
        if (exp_q.size() == 0) begin
          chk("unexpected_window", 1, 0);
        end else begin
          exp_win_t e;
          e = exp_q.pop_front();
          chk("win_a", int'(win_a), e.a);
          chk("win_b", int'(win_b), e.b);
          chk("win_c", int'(win_c), e.c);
          chk("win_d", int'(win_d), e.d);
          chk("frame_done", int'(frame_done), int'(e.last));
        end
      end else begin
        chk("frame_done_idle", int'(frame_done), 0);
      end
    end
  end

  initial begin
    int done0;
    int row01 [8];
    logic signed [DATA_W-1:0] sa, sb, sc, sd;

    n_checks   = 0;
    n_fail     = 0;
    n_done     = 0;
    n_hs       = 0;
    ready_mode = 0;
    win_ready  = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    rst_n      = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_win_valid", int'(win_valid), 0);
    chk("rst_win_a", int'(win_a), 0);
    chk("rst_win_d", int'(win_d), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed frame: first two rows fixed, latency checked on (1,0) and (1,1).
    row01 = '{0, 1, 0, -1, 1, -2, 0, 1};
    random_frame();
    for (int i = 0; i < 8; i++) frame[i / IMG_W][i % IMG_W] = row01[i];
    model_frame();
    done0 = n_done;
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        drive_pixel(frame[r][c], 0);
        if (r == 1 && c == 0) chk("no_win_before_11", int'(win_valid), 0);
        if (r == 1 && c == 1) chk("win_valid_lat1", int'(win_valid), 1);
      end
    end
    drain();
    chk("t1_frame_done_cnt", n_done - done0, 1);
    chk("t1_handshakes", n_hs, 4);

    // Backpressure: hold win_ready low across the first window.
    ready_mode = 2;
    @(posedge clk); #1;
    random_frame();
    model_frame();
    fork
      send_frame(0);
      begin
        int guard;
        guard = 0;
        @(negedge clk);
        while (!win_valid && guard < 100) begin
          guard++;
          @(negedge clk);
        end
        chk("stall_win_seen", int'(win_valid), 1);
        sa = win_a; sb = win_b; sc = win_c; sd = win_d;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("stall_valid", int'(win_valid), 1);
          chk("stall_in_ready", int'(in_ready), 0);
          chk("stall_a", int'(win_a), int'(sa));
          chk("stall_b", int'(win_b), int'(sb));
          chk("stall_c", int'(win_c), int'(sc));
          chk("stall_d", int'(win_d), int'(sd));
        end
        ready_mode = 0;
      end
    join
    drain();

    // Two back-to-back random frames with gaps and random backpressure.
    ready_mode = 1;
    done0 = n_done;
    for (int f = 0; f < 2; f++) begin
      random_frame();
      model_frame();
      send_frame(50);
    end
    drain();
    chk("t4_frame_done_cnt", n_done - done0, 2);
    ready_mode = 0;
    @(posedge clk); #1;

    // Asynchronous reset part-way through row 1, after pixel (1,2).
    random_frame();
    model_frame();
    for (int i = 0; i < IMG_W + 3; i++) drive_pixel(frame[i / IMG_W][i % IMG_W], 0);
    @(negedge clk);
    chk("pre_rst_pending", exp_q.size(), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_win_valid", int'(win_valid), 0);
    chk("arst_win_a", int'(win_a), 0);
    chk("arst_win_b", int'(win_b), 0);
    chk("arst_win_c", int'(win_c), 0);
    chk("arst_win_d", int'(win_d), 0);
    chk("arst_frame_done", int'(frame_done), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("arst_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;

    random_frame();
    model_frame();
    send_frame(0);
    drain();

    // Most-negative pixel everywhere.
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        frame[r][c] = -2;
    model_frame();
    send_frame(0);
    drain();
    chk("neg2_raw_bits", int'($unsigned(win_a)), 2);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout, expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
